// File: rtl/edge_pkg.sv
// Shared constants, FSM state type and counter-width helper for the
// raster-to-window stage feeding the edge detector.
package edge_pkg;

    localparam int IMG_W_DEF = 415;
    localparam int IMG_H_DEF = 738;
    localparam int DW_DEF    = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        FLUSH  = 2'd2
    } state_t;

    // Width of a counter that must hold 0..n-1.
    function automatic int cnt_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/window_3x3_gen_if.sv
// Pixel-in / window-out bundle for window_3x3_gen.
// master = pixel source and window consumer, slave = the windowing block.
interface window_3x3_gen_if
    import edge_pkg::*;
#(
    parameter int IMG_W = IMG_W_DEF,
    parameter int IMG_H = IMG_H_DEF,
    parameter int DW    = DW_DEF
);
    localparam int ROW_W = cnt_w(IMG_H);
    localparam int COL_W = cnt_w(IMG_W);

    logic             in_valid;
    logic [DW-1:0]    in_pixel;
    logic             in_ready;
    logic             out_valid;
    logic [DW-1:0]    p00, p01, p02;
    logic [DW-1:0]    p10, p11, p12;
    logic [DW-1:0]    p20, p21, p22;
    logic [ROW_W-1:0] out_row;
    logic [COL_W-1:0] out_col;
    logic             frame_done;

    modport master (
        output in_valid, in_pixel,
        input  in_ready, out_valid,
        input  p00, p01, p02, p10, p11, p12, p20, p21, p22,
        input  out_row, out_col, frame_done
    );

    modport slave (
        input  in_valid, in_pixel,
        output in_ready, out_valid,
        output p00, p01, p02, p10, p11, p12, p20, p21, p22,
        output out_row, out_col, frame_done
    );

endinterface

// File: rtl/line_buffer.sv
// One image row of storage: register array, asynchronous read,
// synchronous write with enable.
module line_buffer
    import edge_pkg::*;
#(
    parameter int  DEPTH = IMG_W_DEF,
    parameter int  DW    = DW_DEF,
    localparam int AW    = cnt_w(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];

    assign rdata = mem[addr];

    // Write the addressed entry when enabled.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

endmodule

// File: rtl/window_3x3_gen.sv
// Raster-to-3x3-window stage: buffers two rows, shifts columns and emits one
// zero-padded neighbourhood per pixel, centre in raster order.
module window_3x3_gen
    import edge_pkg::*;
#(
    parameter int IMG_W = IMG_W_DEF,
    parameter int IMG_H = IMG_H_DEF,
    parameter int DW    = DW_DEF
) (
    input  logic            clk,
    input  logic            rst,
    window_3x3_gen_if.slave bus
);

    localparam int ROW_W = cnt_w(IMG_H);
    localparam int COL_W = cnt_w(IMG_W);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_ONE  = ROW_W'(1);
    localparam logic [COL_W-1:0] COL_ONE  = COL_W'(1);

    state_t           state_q, state_d;
    logic [ROW_W-1:0] in_row_q, cen_row_q;
    logic [COL_W-1:0] in_col_q, cen_col_q;
    logic             adv, emit, in_last, flush_last, cen_last;
    logic             top_z, bot_z, lft_z, rgt_z;
    logic [DW-1:0]    pix, lb0_rd, lb1_rd;
    // Index 0 = row above centre, 1 = centre row, 2 = row below.
    logic [DW-1:0]    old_col [3];
    logic [DW-1:0]    cur_col [3];
    logic [DW-1:0]    new_col [3];

    assign in_last    = (in_row_q == ROW_LAST) && (in_col_q == COL_LAST);
    assign flush_last = (in_row_q == ROW_ONE) && (in_col_q == '0);
    assign cen_last   = (cen_row_q == ROW_LAST) && (cen_col_q == COL_LAST);
    assign pix        = (state_q == FLUSH) ? '0 : bus.in_pixel;
    assign bus.in_ready = (state_q != FLUSH);

    // A window is complete once linear index IMG_W+1 has been reached;
    // every flush step completes one of the trailing windows.
    assign emit = adv && ((state_q == FLUSH) || (in_row_q > ROW_ONE) ||
                          ((in_row_q == ROW_ONE) && (in_col_q != '0)));

    assign top_z = (cen_row_q == '0);
    assign bot_z = (cen_row_q == ROW_LAST);
    assign lft_z = (cen_col_q == '0);
    assign rgt_z = (cen_col_q == COL_LAST);

    line_buffer #(.DEPTH(IMG_W), .DW(DW)) u_lb0 (
        .clk   (clk),
        .we    (adv),
        .addr  (in_col_q),
        .wdata (pix),
        .rdata (lb0_rd)
    );

    line_buffer #(.DEPTH(IMG_W), .DW(DW)) u_lb1 (
        .clk   (clk),
        .we    (adv),
        .addr  (in_col_q),
        .wdata (lb0_rd),
        .rdata (lb1_rd)
    );

    // Next-state and advance decode.
    always_comb begin
        state_d = state_q;
        adv     = 1'b0;
        unique case (state_q)
            IDLE: begin
                adv = bus.in_valid;
                if (bus.in_valid) state_d = STREAM;
            end
            STREAM: begin
                adv = bus.in_valid;
                if (bus.in_valid && in_last) state_d = FLUSH;
            end
            FLUSH: begin
                adv = 1'b1;
                if (flush_last) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Input position; flush reuses it to count its IMG_W+1 steps, then it
    // is rewound so the next frame starts at (0,0).
    always_ff @(posedge clk) begin
        if (rst) begin
            in_row_q <= '0;
            in_col_q <= '0;
        end else if (adv) begin
            if ((state_q == FLUSH) && flush_last) begin
                in_row_q <= '0;
                in_col_q <= '0;
            end else if (in_col_q == COL_LAST) begin
                in_col_q <= '0;
                in_row_q <= (in_row_q == ROW_LAST) ? '0 : in_row_q + ROW_ONE;
            end else begin
                in_col_q <= in_col_q + COL_ONE;
            end
        end
    end

    // Newest column: rows r-1, r, r+1 at column c+1.
    always_comb begin
        new_col[0] = lb1_rd;
        new_col[1] = lb0_rd;
        new_col[2] = pix;
    end

    // Column shift register (the newest column stays combinational).
    always_ff @(posedge clk) begin
        if (adv) begin
            old_col <= cur_col;
            cur_col <= new_col;
        end
    end

    // Centre position of the next window to be emitted.
    always_ff @(posedge clk) begin
        if (rst) begin
            cen_row_q <= '0;
            cen_col_q <= '0;
        end else if (emit) begin
            if (cen_col_q == COL_LAST) begin
                cen_col_q <= '0;
                cen_row_q <= (cen_row_q == ROW_LAST) ? '0 : cen_row_q + ROW_ONE;
            end else begin
                cen_col_q <= cen_col_q + COL_ONE;
            end
        end
    end

    // Output window register with border zero padding.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.out_valid  <= 1'b0;
            bus.frame_done <= 1'b0;
            bus.out_row    <= '0;
            bus.out_col    <= '0;
            bus.p00 <= '0; bus.p01 <= '0; bus.p02 <= '0;
            bus.p10 <= '0; bus.p11 <= '0; bus.p12 <= '0;
            bus.p20 <= '0; bus.p21 <= '0; bus.p22 <= '0;
        end else begin
            bus.out_valid  <= emit;
            bus.frame_done <= emit && cen_last;
            if (emit) begin
                bus.out_row <= cen_row_q;
                bus.out_col <= cen_col_q;
                bus.p00 <= (top_z || lft_z) ? '0 : old_col[0];
                bus.p01 <= top_z            ? '0 : cur_col[0];
                bus.p02 <= (top_z || rgt_z) ? '0 : new_col[0];
                bus.p10 <= lft_z            ? '0 : old_col[1];
                bus.p11 <= cur_col[1];
                bus.p12 <= rgt_z            ? '0 : new_col[1];
                bus.p20 <= (bot_z || lft_z) ? '0 : old_col[2];
                bus.p21 <= bot_z            ? '0 : cur_col[2];
                bus.p22 <= (bot_z || rgt_z) ? '0 : new_col[2];
            end
        end
    end

endmodule

// File: tb/tb_window_3x3_gen.sv
// Directed bench for window_3x3_gen on a 4x3 frame, pixel = r*4+c+1(+offset).
module tb_window_3x3_gen;

    localparam int W  = 4;
    localparam int H  = 3;
    localparam int DW = 8;

    typedef struct {
        logic [71:0] w;
        int          row;
        int          col;
        logic        fd;
        int          cyc;
    } rec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    rec_t q[$];

    window_3x3_gen_if #(.IMG_W(W), .IMG_H(H), .DW(DW)) bus ();

    window_3x3_gen #(.IMG_W(W), .IMG_H(H), .DW(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Log every emitted window away from the active edge.
    always @(negedge clk) begin
        if (!rst && bus.out_valid) begin
            q.push_back('{w: {bus.p00, bus.p01, bus.p02, bus.p10, bus.p11, bus.p12,
                              bus.p20, bus.p21, bus.p22},
                          row: int'(bus.out_row), col: int'(bus.out_col),
                          fd: bus.frame_done, cyc: cyc});
        end
    end

    function automatic logic [71:0] model(input int r, input int c, input int off);
        logic [71:0] v;
        v = '0;
        for (int dr = 0; dr < 3; dr++) begin
            for (int dc = 0; dc < 3; dc++) begin
                int rr, cc;
                rr = r + dr - 1;
                cc = c + dc - 1;
                if (rr >= 0 && rr < H && cc >= 0 && cc < W)
                    v[71 - 8*(dr*3+dc) -: 8] = 8'(rr*W + cc + 1 + off);
            end
        end
        return v;
    endfunction

    task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive for one cycle starting at a negedge; returns at the next negedge.
    task automatic tick(input logic v, input logic [7:0] p, output logic acc);
        bus.in_valid = v;
        bus.in_pixel = p;
        acc = v && bus.in_ready;
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic send(input logic [7:0] p, output int acc_cyc);
        logic acc;
        acc = 1'b0;
        acc_cyc = -1;
        for (int k = 0; k < 40 && !acc; k++) begin
            acc_cyc = cyc;
            tick(1'b1, p, acc);
        end
        if (!acc) check("send_timeout", 72'd0, 72'd1);
    endtask

    task automatic idle(input int n);
        logic acc;
        for (int k = 0; k < n; k++) tick(1'b0, 8'd0, acc);
    endtask

    task automatic check_frame(input string tag, input int base, input int off);
        for (int i = 0; i < W*H; i++) begin
            if (base + i < q.size()) begin
                check($sformatf("%s_w%0d", tag, i), q[base+i].w, model(i / W, i % W, off));
                check($sformatf("%s_rc%0d", tag, i),
                      72'(q[base+i].row * 16 + q[base+i].col), 72'((i / W) * 16 + (i % W)));
            end
        end
    endtask

    initial begin
        logic [71:0] w00, w11, w23, w00b;
        int acc_c [W*H];
        int acc_b0, low_cnt, fd_cnt;
        logic acc;

        w00  = {8'd0, 8'd0, 8'd0,   8'd0, 8'd1,   8'd2,   8'd0, 8'd5,   8'd6};
        w11  = {8'd1, 8'd2, 8'd3,   8'd5, 8'd6,   8'd7,   8'd9, 8'd10,  8'd11};
        w23  = {8'd7, 8'd8, 8'd0,   8'd11, 8'd12, 8'd0,   8'd0, 8'd0,   8'd0};
        w00b = {8'd0, 8'd0, 8'd0,   8'd0, 8'd101, 8'd102, 8'd0, 8'd105, 8'd106};

        bus.in_valid = 1'b0;
        bus.in_pixel = '0;
        @(negedge clk);
        rst = 1'b1;
        idle(2);
        rst = 1'b0;

        // Reset state.
        check("rst_in_ready",   72'(bus.in_ready),   72'd1);
        check("rst_out_valid",  72'(bus.out_valid),  72'd0);
        check("rst_frame_done", 72'(bus.frame_done), 72'd0);
        check("rst_rowcol",     72'({bus.out_row, bus.out_col}), 72'd0);
        check("rst_window", {bus.p00, bus.p01, bus.p02, bus.p10, bus.p11, bus.p12,
                             bus.p20, bus.p21, bus.p22}, 72'd0);

        // Continuous frame.
        q.delete();
        for (int i = 0; i < W*H; i++) send(8'(i + 1), acc_c[i]);
        low_cnt = 0;
        for (int k = 0; k < 20 && !bus.in_ready; k++) begin
            low_cnt++;
            tick(1'b0, 8'd0, acc);
        end
        check("ready_low_cycles", 72'(low_cnt), 72'(W + 1));
        check("fd_with_ready",    72'(bus.frame_done), 72'd1);
        idle(4);
        check("cont_count", 72'(q.size()), 72'(W*H));
        if (q.size() == W*H) begin
            check("first_latency", 72'(q[0].cyc), 72'(acc_c[W+1] + 1));
            check("win00", q[0].w, w00);
            check("win11", q[5].w, w11);
            check("win23", q[11].w, w23);
            check("fd_last", 72'(q[11].fd), 72'd1);
            fd_cnt = 0;
            foreach (q[i]) if (q[i].fd) fd_cnt++;
            check("fd_count", 72'(fd_cnt), 72'd1);
            check_frame("cont", 0, 0);
        end

        // Random input gaps.
        q.delete();
        for (int i = 0; i < W*H; i++) begin
            if (i > 0) begin
                int g;
                g = (i % 4 == 1) ? 2 : int'($urandom_range(0, 2));
                for (int k = 0; k < g; k++) begin
                    tick(1'b0, 8'd0, acc);
                    check("gap_out_valid", 72'(bus.out_valid), 72'd0);
                end
            end
            send(8'(i + 1), acc_c[i]);
        end
        idle(W + 4);
        check("gap_count", 72'(q.size()), 72'(W*H));
        check_frame("gap", 0, 0);

        // Reset mid-frame, then a fresh frame.
        for (int i = 0; i < 7; i++) send(8'(i + 1), acc_c[i]);
        rst = 1'b1;
        tick(1'b0, 8'd0, acc);
        rst = 1'b0;
        check("midrst_out_valid", 72'(bus.out_valid), 72'd0);
        check("midrst_in_ready",  72'(bus.in_ready),  72'd1);
        q.delete();
        for (int i = 0; i < W*H; i++) send(8'(i + 1), acc_c[i]);
        idle(W + 4);
        check("midrst_count", 72'(q.size()), 72'(W*H));
        if (q.size() > 0) begin
            check("midrst_win00", q[0].w, w00);
            check("midrst_rc00", 72'(q[0].row * 16 + q[0].col), 72'd0);
        end

        // Two back-to-back frames, second offset by 100.
        q.delete();
        for (int i = 0; i < W*H; i++) send(8'(i + 1), acc_c[i]);
        for (int i = 0; i < W*H; i++) begin
            int c;
            send(8'(i + 101), c);
            if (i == 0) acc_b0 = c;
        end
        idle(W + 4);
        check("b2b_count", 72'(q.size()), 72'(2*W*H));
        if (q.size() == 2*W*H) begin
            check("b2b_fd_a", 72'(q[W*H-1].fd), 72'd1);
            check("b2b_accept_on_fd", 72'(acc_b0), 72'(q[W*H-1].cyc));
            check("b2b_win00_b", q[W*H].w, w00b);
            check_frame("b2b_a", 0, 0);
            check_frame("b2b_b", W*H, 100);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
